// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: picks a victim way, refills the 16-word block
// in 4 memory beats, writes tag/status, forwards the critical word, then restarts.
module icache_refill_ctrl #(
   parameter int TAG_BITS_WIDTH          = 8,
   parameter int SET_BITS_WIDTH          = 4,
   parameter int BLOCK_OFFSET_BITS_WIDTH = 4,
   parameter int WORD_WIDTH              = 20,
   parameter int NUM_WAYS                = 4,
   parameter int MEM_IF_DATA_WIDTH       = 128,
   parameter int MEM_IF_ADDR_WIDTH       = 16,
   parameter int WORDS_PER_BEAT          = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   i_miss_valid,
   input  logic [TAG_BITS_WIDTH-1:0]              i_miss_tag,
   input  logic [SET_BITS_WIDTH-1:0]              i_miss_set,
   input  logic [BLOCK_OFFSET_BITS_WIDTH-1:0]     i_miss_offset,
   input  logic [2*NUM_WAYS-1:0]                  i_miss_status,
   output logic                                   o_miss_ready,
   output logic [MEM_IF_ADDR_WIDTH-1:0]           o_mem_addr,
   output logic                                   o_mem_req_valid,
   input  logic                                   i_mem_req_ready,
   input  logic [MEM_IF_DATA_WIDTH-1:0]           i_mem_data,
   input  logic                                   i_mem_data_valid,
   output logic [SET_BITS_WIDTH+BLOCK_OFFSET_BITS_WIDTH-$clog2(WORDS_PER_BEAT)-1:0] o_da_w_addr,
   output logic [WORDS_PER_BEAT*WORD_WIDTH-1:0]   o_da_w_data,
   output logic [NUM_WAYS-1:0]                    o_da_w_way_mask,
   output logic                                   o_da_w_valid,
   output logic [SET_BITS_WIDTH-1:0]              o_ta_w_addr,
   output logic [NUM_WAYS*TAG_BITS_WIDTH-1:0]     o_ta_w_data,
   output logic [NUM_WAYS-1:0]                    o_ta_w_wmask,
   output logic                                   o_ta_w_valid,
   output logic [SET_BITS_WIDTH-1:0]              o_sa_w_addr,
   output logic [2*NUM_WAYS-1:0]                  o_sa_w_data,
   output logic                                   o_sa_w_valid,
   output logic [WORD_WIDTH-1:0]                  o_crit_data,
   output logic                                   o_crit_valid,
   output logic                                   o_busy,
   output logic                                   o_restart
);

   localparam int WPB_W  = $clog2(WORDS_PER_BEAT);
   localparam int CNT_W  = BLOCK_OFFSET_BITS_WIDTH - WPB_W;
   localparam int WAY_W  = $clog2(NUM_WAYS);
   localparam int DA_W   = WORDS_PER_BEAT * WORD_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_FILL,
      S_UPDATE,
      S_RESTART
   } state_t;

   state_t state, state_next;

   logic [TAG_BITS_WIDTH-1:0]          tag_q;
   logic [SET_BITS_WIDTH-1:0]          set_q;
   logic [BLOCK_OFFSET_BITS_WIDTH-1:0] offset_q;
   logic [NUM_WAYS-1:0]                way_mask_q;
   logic [2*NUM_WAYS-1:0]              status_q;
   logic [CNT_W-1:0]                   beat_cnt;

   logic [WAY_W-1:0]                   victim_idx;
   logic                               victim_found;
   logic                               all_aged;
   logic [2*NUM_WAYS-1:0]              new_status;
   logic [WORD_WIDTH-1:0]              crit_word;
   logic                               beat_fire;
   logic                               unused_mem_bits;

   assign beat_fire       = (state == S_FILL) && i_mem_data_valid;
   assign unused_mem_bits = ^i_mem_data[MEM_IF_DATA_WIDTH-1:DA_W];

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    if (i_miss_valid) state_next = S_REQ;
         S_REQ:     if (i_mem_req_ready) state_next = S_FILL;
         S_FILL:    if (beat_fire && (beat_cnt == CNT_W'(WORDS_PER_BEAT - 1))) state_next = S_UPDATE;
         S_UPDATE:  state_next = S_RESTART;
         S_RESTART: state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   // Victim choice prefers an empty way, then a way not recently used, then way 0;
   // the replacement status is computed at acceptance time from the incoming word.
   always_comb begin
      victim_idx   = '0;
      victim_found = 1'b0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!victim_found && !i_miss_status[2*w+1]) begin
            victim_idx   = WAY_W'(w);
            victim_found = 1'b1;
         end
      end
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!victim_found && !i_miss_status[2*w]) begin
            victim_idx   = WAY_W'(w);
            victim_found = 1'b1;
         end
      end
      new_status = i_miss_status;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (WAY_W'(w) == victim_idx) new_status[2*w +: 2] = 2'b11;
      end
      all_aged = 1'b1;
      for (int w = 0; w < NUM_WAYS; w++) begin
         all_aged = all_aged & new_status[2*w];
      end
      if (all_aged) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            if (WAY_W'(w) != victim_idx) new_status[2*w] = 1'b0;
         end
      end
   end

   always_comb begin
      crit_word = '0;
      for (int k = 0; k < WORDS_PER_BEAT; k++) begin
         if (WPB_W'(k) == offset_q[WPB_W-1:0]) crit_word = i_mem_data[k*WORD_WIDTH +: WORD_WIDTH];
      end
   end

   // Registered datapath and strobes; pulses default low every cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_q           <= '0;
         set_q           <= '0;
         offset_q        <= '0;
         way_mask_q      <= '0;
         status_q        <= '0;
         beat_cnt        <= '0;
         o_da_w_valid    <= 1'b0;
         o_da_w_addr     <= '0;
         o_da_w_data     <= '0;
         o_crit_valid    <= 1'b0;
         o_crit_data     <= '0;
         o_ta_w_valid    <= 1'b0;
         o_sa_w_valid    <= 1'b0;
         o_restart       <= 1'b0;
      end else begin
         o_da_w_valid <= 1'b0;
         o_crit_valid <= 1'b0;
         o_ta_w_valid <= (state == S_UPDATE);
         o_sa_w_valid <= (state == S_UPDATE);
         o_restart    <= (state == S_RESTART);
         if ((state == S_IDLE) && i_miss_valid) begin
            tag_q      <= i_miss_tag;
            set_q      <= i_miss_set;
            offset_q   <= i_miss_offset;
            way_mask_q <= NUM_WAYS'(1) << victim_idx;
            status_q   <= new_status;
            beat_cnt   <= '0;
         end
         if (beat_fire) begin
            o_da_w_valid <= 1'b1;
            o_da_w_addr  <= {set_q, beat_cnt};
            o_da_w_data  <= i_mem_data[DA_W-1:0];
            beat_cnt     <= beat_cnt + 1'b1;
            if (beat_cnt == offset_q[BLOCK_OFFSET_BITS_WIDTH-1:WPB_W]) begin
               o_crit_valid <= 1'b1;
               o_crit_data  <= crit_word;
            end
         end
      end
   end

   assign o_miss_ready    = (state == S_IDLE);
   assign o_busy          = (state != S_IDLE);
   assign o_mem_req_valid = (state == S_REQ);
   assign o_mem_addr      = {tag_q, set_q, {BLOCK_OFFSET_BITS_WIDTH{1'b0}}};
   assign o_da_w_way_mask = way_mask_q;
   assign o_ta_w_addr     = set_q;
   assign o_ta_w_data     = {NUM_WAYS{tag_q}};
   assign o_ta_w_wmask    = way_mask_q;
   assign o_sa_w_addr     = set_q;
   assign o_sa_w_data     = status_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: stimulus pushes expected writes into
// queues, a negedge monitor pops and compares whatever the DUT presents.
module tb_icache_refill_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_miss_valid;
   logic [7:0]   i_miss_tag;
   logic [3:0]   i_miss_set;
   logic [3:0]   i_miss_offset;
   logic [7:0]   i_miss_status;
   logic         o_miss_ready;
   logic [15:0]  o_mem_addr;
   logic         o_mem_req_valid;
   logic         i_mem_req_ready;
   logic [127:0] i_mem_data;
   logic         i_mem_data_valid;
   logic [5:0]   o_da_w_addr;
   logic [79:0]  o_da_w_data;
   logic [3:0]   o_da_w_way_mask;
   logic         o_da_w_valid;
   logic [3:0]   o_ta_w_addr;
   logic [31:0]  o_ta_w_data;
   logic [3:0]   o_ta_w_wmask;
   logic         o_ta_w_valid;
   logic [3:0]   o_sa_w_addr;
   logic [7:0]   o_sa_w_data;
   logic         o_sa_w_valid;
   logic [19:0]  o_crit_data;
   logic         o_crit_valid;
   logic         o_busy;
   logic         o_restart;

   icache_refill_ctrl dut (
      .clk(clk), .rst(rst),
      .i_miss_valid(i_miss_valid), .i_miss_tag(i_miss_tag), .i_miss_set(i_miss_set),
      .i_miss_offset(i_miss_offset), .i_miss_status(i_miss_status), .o_miss_ready(o_miss_ready),
      .o_mem_addr(o_mem_addr), .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
      .i_mem_data(i_mem_data), .i_mem_data_valid(i_mem_data_valid),
      .o_da_w_addr(o_da_w_addr), .o_da_w_data(o_da_w_data), .o_da_w_way_mask(o_da_w_way_mask),
      .o_da_w_valid(o_da_w_valid), .o_ta_w_addr(o_ta_w_addr), .o_ta_w_data(o_ta_w_data),
      .o_ta_w_wmask(o_ta_w_wmask), .o_ta_w_valid(o_ta_w_valid), .o_sa_w_addr(o_sa_w_addr),
      .o_sa_w_data(o_sa_w_data), .o_sa_w_valid(o_sa_w_valid), .o_crit_data(o_crit_data),
      .o_crit_valid(o_crit_valid), .o_busy(o_busy), .o_restart(o_restart)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  addr;
      logic [79:0] data;
      logic [3:0]  mask;
      bit          last;
   } da_exp_t;

   typedef struct {
      logic [3:0]  set;
      logic [31:0] tag_data;
      logic [3:0]  mask;
      logic [7:0]  status;
   } upd_exp_t;

   da_exp_t     da_q[$];
   logic [19:0] crit_q[$];
   upd_exp_t    upd_q[$];
   int          restart_pending = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          cycle = 0;
   int          last_wr_cycle = -100;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Reference model: first empty way, else first way with age clear, else way 0
   function automatic int model_victim(input logic [7:0] st);
      for (int w = 0; w < 4; w++) if (st[2*w+1] == 1'b0) return w;
      for (int w = 0; w < 4; w++) if (st[2*w] == 1'b0) return w;
      return 0;
   endfunction

   function automatic logic [7:0] model_status(input logic [7:0] st, input int victim);
      logic [7:0] s;
      int aged;
      s = st;
      s[2*victim +: 2] = 2'b11;
      aged = 0;
      for (int w = 0; w < 4; w++) aged += s[2*w];
      if (aged == 4) for (int w = 0; w < 4; w++) if (w != victim) s[2*w] = 1'b0;
      return s;
   endfunction

   // Monitor: every strobe the DUT raises must match the head of its queue
   always @(negedge clk) begin : monitor
      da_exp_t  de;
      upd_exp_t ue;
      logic [19:0] ce;
      if (o_da_w_valid === 1'b1) begin
         if (da_q.size() == 0) checkOutput("da_unexpected", 1, 0);
         else begin
            de = da_q.pop_front();
            checkOutput("da_addr", o_da_w_addr, de.addr);
            checkOutput("da_data", o_da_w_data, de.data);
            checkOutput("da_mask", o_da_w_way_mask, de.mask);
            if (de.last) last_wr_cycle = cycle;
         end
      end
      if (o_crit_valid === 1'b1) begin
         if (crit_q.size() == 0) checkOutput("crit_unexpected", 1, 0);
         else begin
            ce = crit_q.pop_front();
            checkOutput("crit_data", o_crit_data, ce);
         end
      end
      if (o_ta_w_valid === 1'b1 || o_sa_w_valid === 1'b1) begin
         checkOutput("ta_sa_together", o_ta_w_valid, o_sa_w_valid);
         if (upd_q.size() == 0) checkOutput("update_unexpected", 1, 0);
         else begin
            ue = upd_q.pop_front();
            checkOutput("ta_addr", o_ta_w_addr, ue.set);
            checkOutput("ta_data", o_ta_w_data, ue.tag_data);
            checkOutput("ta_wmask", o_ta_w_wmask, ue.mask);
            checkOutput("sa_addr", o_sa_w_addr, ue.set);
            checkOutput("sa_data", o_sa_w_data, ue.status);
            checkOutput("update_latency", cycle, last_wr_cycle + 1);
         end
      end
      if (o_restart === 1'b1) begin
         if (restart_pending == 0) checkOutput("restart_unexpected", 1, 0);
         else begin
            restart_pending--;
            checkOutput("restart_latency", cycle, last_wr_cycle + 2);
         end
      end
   end

   function automatic logic [127:0] rand_beat();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One complete miss transaction; abort_beats < 4 resets the DUT after that many beats
   task automatic applyStimulus(input logic [7:0] tag, input logic [3:0] set, input logic [3:0] off,
                                input logic [7:0] st, input int req_delay, input int max_gap,
                                input int abort_beats, input bit hold_miss, input bit stray);
      int          victim;
      int          waited;
      int          k;
      logic [3:0]  mask;
      logic [7:0]  nst;
      logic [127:0] beat;
      victim = model_victim(st);
      mask   = 4'b0001 << victim;
      nst    = model_status(st, victim);
      if (stray) begin
         i_mem_data = rand_beat();
         i_mem_data_valid = 1'b1;
         @(posedge clk); #1;
         i_mem_data_valid = 1'b0;
      end
      waited = 0;
      while (o_miss_ready !== 1'b1 && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      checkOutput("miss_ready_idle", o_miss_ready, 1);
      i_miss_valid = 1'b1;
      i_miss_tag = tag; i_miss_set = set; i_miss_offset = off; i_miss_status = st;
      @(posedge clk); #1;
      if (hold_miss) begin
         i_miss_tag = 8'($urandom); i_miss_set = 4'($urandom);
         i_miss_offset = 4'($urandom); i_miss_status = 8'($urandom);
      end else begin
         i_miss_valid = 1'b0;
      end
      checkOutput("req_valid", o_mem_req_valid, 1);
      checkOutput("mem_addr", o_mem_addr, {tag, set, 4'h0});
      checkOutput("miss_ready_busy", o_miss_ready, 0);
      for (int i = 0; i < req_delay; i++) begin
         i_mem_req_ready = 1'b0;
         i_mem_data = rand_beat();
         i_mem_data_valid = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         checkOutput("req_hold_valid", o_mem_req_valid, 1);
         checkOutput("req_hold_addr", o_mem_addr, {tag, set, 4'h0});
         checkOutput("req_busy", o_busy, 1);
      end
      i_mem_data_valid = 1'b0;
      i_mem_req_ready = 1'b1;
      @(posedge clk); #1;
      i_mem_req_ready = 1'b0;
      checkOutput("req_dropped", o_mem_req_valid, 0);
      for (int b = 0; b < 4; b++) begin
         if (b == abort_beats) break;
         repeat ($urandom_range(0, max_gap)) begin
            i_mem_data = rand_beat();
            @(posedge clk); #1;
         end
         beat = rand_beat();
         i_mem_data = beat;
         i_mem_data_valid = 1'b1;
         da_q.push_back('{addr: {set, 2'(b)}, data: beat[79:0], mask: mask, last: (b == 3)});
         if (b == int'(off[3:2])) begin
            k = int'(off[1:0]);
            crit_q.push_back(beat[k*20 +: 20]);
         end
         if (b == 3) begin
            upd_q.push_back('{set: set, tag_data: {4{tag}}, mask: mask, status: nst});
            restart_pending++;
         end
         @(posedge clk); #1;
         i_mem_data_valid = 1'b0;
         if (hold_miss) checkOutput("miss_held_ignored", o_miss_ready, 0);
      end
      i_miss_valid = 1'b0;
      if (abort_beats < 4) begin
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         checkOutput("abort_idle_ready", o_miss_ready, 1);
         checkOutput("abort_not_busy", o_busy, 0);
         checkOutput("abort_no_ta", o_ta_w_valid, 0);
         checkOutput("abort_no_sa", o_sa_w_valid, 0);
         checkOutput("abort_da_drained", da_q.size(), 0);
         crit_q.delete();
      end else begin
         waited = 0;
         while (o_miss_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
         end
         checkOutput("return_idle", o_miss_ready, 1);
         @(posedge clk); #1;
         checkOutput("da_q_empty", da_q.size(), 0);
         checkOutput("crit_q_empty", crit_q.size(), 0);
         checkOutput("upd_q_empty", upd_q.size(), 0);
         checkOutput("restart_seen", restart_pending, 0);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      i_miss_valid = 1'b0; i_miss_tag = '0; i_miss_set = '0; i_miss_offset = '0; i_miss_status = '0;
      i_mem_req_ready = 1'b0; i_mem_data = '0; i_mem_data_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_miss_ready", o_miss_ready, 1);
      checkOutput("rst_busy", o_busy, 0);
      checkOutput("rst_req_valid", o_mem_req_valid, 0);
      checkOutput("rst_mem_addr", o_mem_addr, 0);
      checkOutput("rst_da_valid", o_da_w_valid, 0);
      checkOutput("rst_crit_valid", o_crit_valid, 0);
      checkOutput("rst_ta_valid", o_ta_w_valid, 0);
      checkOutput("rst_restart", o_restart, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      $display("[TB] directed: basic refill into empty set");
      applyStimulus(8'h3A, 4'h5, 4'h9, 8'h00, 0, 0, 4, 1'b0, 1'b0);
      $display("[TB] directed: full set with one young way");
      applyStimulus(8'hC4, 4'h2, 4'h3, 8'hFB, 0, 0, 4, 1'b0, 1'b0);
      $display("[TB] directed: memory request stalled");
      applyStimulus(8'h11, 4'hF, 4'hF, 8'h55, 5, 0, 4, 1'b0, 1'b0);
      $display("[TB] directed: gaps between beats and stray beat in idle");
      applyStimulus(8'h7E, 4'h0, 4'h0, 8'hFF, 1, 3, 4, 1'b0, 1'b1);
      $display("[TB] directed: reset after two beats, then clean refill");
      applyStimulus(8'h99, 4'h6, 4'hC, 8'h0F, 0, 1, 2, 1'b0, 1'b0);
      applyStimulus(8'h99, 4'h6, 4'hC, 8'h0F, 0, 1, 4, 1'b0, 1'b0);
      $display("[TB] directed: miss held during fill");
      applyStimulus(8'hA5, 4'h9, 4'h6, 8'hAA, 2, 1, 4, 1'b1, 1'b0);
      applyStimulus(8'h5A, 4'h3, 4'h1, 8'hEE, 0, 0, 4, 1'b0, 1'b0);

      $display("[TB] randomized transactions");
      for (int t = 0; t < 40; t++) begin
         applyStimulus(8'($urandom), 4'($urandom), 4'($urandom), 8'($urandom),
                       $urandom_range(0, 3), $urandom_range(0, 2),
                       ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 4,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
